// File: rtl/tcp_active_conn_manager.sv
// tcp_active_conn_manager: client-side TCP open/close state machine tracking local and remote sequence numbers.
module tcp_active_conn_manager #(
  parameter logic [31:0] ISN = 32'h0001_0000,
  parameter int SYN_TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_SYN_RETRIES = 3,
  parameter int FIN_TIMEOUT_CYCLES = 1_000_000,
  parameter int TIME_WAIT_CYCLES = 2_000_000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        connect_req,
  input  logic        close_req,
  input  logic [31:0] remote_ip,
  input  logic [47:0] remote_mac,
  input  logic [15:0] remote_port,
  input  logic        rx_valid,
  input  logic        syn,
  input  logic        ack,
  input  logic        fin,
  input  logic        rst,
  input  logic [31:0] seq_number,
  input  logic [31:0] ack_number,
  input  logic [15:0] data_len,
  input  logic        tx_data_sent,
  input  logic [15:0] tx_data_len,
  input  logic        disconnect_signal,
  output logic [31:0] seq_number_local,
  output logic [31:0] ack_number_local,
  output logic [31:0] tx_ip,
  output logic [47:0] tx_mac,
  output logic [15:0] tx_port,
  output logic        send_syn,
  output logic        send_ack,
  output logic        send_fin,
  output logic        established_moment,
  output logic        connect_fail,
  output logic [3:0]  tcp_state
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, SYN_SENT = 4'd2, ESTABLISHED = 4'd3, FIN_WAIT_1 = 4'd4,
    FIN_WAIT_2 = 4'd5, CLOSE_WAIT = 4'd6, LAST_ACK = 4'd7, TIME_WAIT = 4'd8
  } state_t;
  localparam logic [31:0] SYN_LAST = 32'(SYN_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] FIN_LAST = 32'(FIN_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TW_LAST = 32'(TIME_WAIT_CYCLES - 1);
  localparam logic [7:0] RETRY_MAX = 8'(MAX_SYN_RETRIES);
  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction
  state_t state;
  logic [31:0] l_seq, l_ack, timer, rseq, rack, fin_seq;
  logic [7:0] retries;
  logic seg, rx, rst_ok;
  assign rseq = bswap(seq_number);
  assign rack = bswap(ack_number);
  assign seg = rx_valid && state != IDLE;
  assign rx = seg && !rst;
  // the FIN's own +1 is folded in while its strobe is still on the wire
  assign fin_seq = l_seq + {31'd0, send_fin};
  assign rst_ok = state == SYN_SENT ? rack == l_seq + 32'd1 : rseq == l_ack;
  assign seq_number_local = bswap(l_seq);
  assign ack_number_local = bswap(l_ack);
  assign tcp_state = state;
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
      l_seq <= '0;
      l_ack <= '0;
      timer <= '0;
      retries <= '0;
      tx_ip <= '0;
      tx_mac <= '0;
      tx_port <= '0;
      send_syn <= 1'b0;
      send_ack <= 1'b0;
      send_fin <= 1'b0;
      established_moment <= 1'b0;
      connect_fail <= 1'b0;
    end else begin
      send_syn <= 1'b0;
      send_ack <= 1'b0;
      send_fin <= 1'b0;
      established_moment <= 1'b0;
      connect_fail <= 1'b0;
      if (disconnect_signal) begin
        state <= IDLE;
        timer <= '0;
        retries <= '0;
      end else if (seg && rst && rst_ok) begin
        state <= IDLE;
        timer <= '0;
        connect_fail <= state == SYN_SENT;
      end else begin
        case (state)
          IDLE: if (connect_req) begin
            tx_ip <= remote_ip;
            tx_mac <= remote_mac;
            tx_port <= remote_port;
            l_seq <= ISN;
            send_syn <= 1'b1;
            retries <= '0;
            timer <= '0;
            state <= SYN_SENT;
          end
          SYN_SENT: if (rx && syn && ack && rack == ISN + 32'd1) begin
            l_ack <= rseq + 32'd1;
            l_seq <= ISN + 32'd1;
            send_ack <= 1'b1;
            established_moment <= 1'b1;
            state <= ESTABLISHED;
          end else if (timer == SYN_LAST) begin
            timer <= '0;
            if (retries < RETRY_MAX) begin
              send_syn <= 1'b1;
              retries <= retries + 8'd1;
            end else begin
              connect_fail <= 1'b1;
              state <= IDLE;
            end
          end else timer <= timer + 32'd1;
          ESTABLISHED: begin
            if (rx && fin && ack && rseq == l_ack) begin
              l_ack <= l_ack + 32'd1;
              send_ack <= 1'b1;
              state <= CLOSE_WAIT;
            end else begin
              if (rx && ack && rseq == l_ack) begin
                l_ack <= l_ack + {16'd0, data_len};
                send_ack <= data_len != 16'd0;
              end else if (rx && rseq != l_ack) send_ack <= 1'b1;
              if (close_req) begin
                send_fin <= 1'b1;
                timer <= '0;
                state <= FIN_WAIT_1;
              end
            end
            if (tx_data_sent) l_seq <= l_seq + {16'd0, tx_data_len};
          end
          FIN_WAIT_1: begin
            l_seq <= fin_seq;
            if (rx && fin) begin
              l_ack <= l_ack + 32'd1;
              send_ack <= 1'b1;
              timer <= '0;
              state <= TIME_WAIT;
            end else if (rx && ack && rack == fin_seq) begin
              timer <= '0;
              state <= FIN_WAIT_2;
            end else if (timer == FIN_LAST) begin
              timer <= '0;
              state <= IDLE;
            end else timer <= timer + 32'd1;
          end
          FIN_WAIT_2: if (rx && fin && rseq == l_ack) begin
            l_ack <= l_ack + 32'd1;
            send_ack <= 1'b1;
            timer <= '0;
            state <= TIME_WAIT;
          end else if (timer == FIN_LAST) begin
            timer <= '0;
            state <= IDLE;
          end else timer <= timer + 32'd1;
          CLOSE_WAIT: begin
            send_fin <= 1'b1;
            state <= LAST_ACK;
          end
          LAST_ACK: begin
            l_seq <= fin_seq;
            if (rx && ack && rack == fin_seq) state <= IDLE;
          end
          TIME_WAIT: if (rx && fin && rseq == l_ack - 32'd1) begin
            send_ack <= 1'b1;
            timer <= '0;
          end else if (timer == TW_LAST) begin
            timer <= '0;
            state <= IDLE;
          end else timer <= timer + 32'd1;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
